boron_round_ctrl: RTL
=====================

Name: boron_round_ctrl

Overview:
- Iterative round sequencer for the BORON 64-bit block encryption datapath.
- Owns the 64-bit cipher state register and the round counter.
- Each cycle it drives the shared combinational round function (key add, S-box layer, small-block shuffle/permutation layer) and indexes the key scheduler.
- Applies final key whitening, then presents the ciphertext with a valid/ready handshake.

Parameters:
- NUM_ROUNDS, 25, number of full rounds before final whitening (legal range 1..31).
- BLOCK_W, 64, cipher state width in bits.
- CNT_W, 5, round/key index width; must satisfy 2^CNT_W > NUM_ROUNDS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  controller idle and accepting plaintext.
- plaintext  in  BLOCK_W  block to encrypt; sampled on the accept edge.
- rf_in  out  BLOCK_W  current state to the round function (= state register).
- rf_round  out  CNT_W  current round index to the round function.
- rf_out  in  BLOCK_W  combinational round-function result for rf_in/rf_round.
- key_idx  out  CNT_W  round-key index to the key scheduler.
- rk_in  in  BLOCK_W  combinational round key for key_idx.
- busy  out  1  high in ROUND and FINAL.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- ciphertext  out  BLOCK_W  result (= state register); stable while out_valid=1.

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous, active-low.
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE; state and round counter are cleared to 0.
  - Outputs: in_ready=1, busy=0, out_valid=0, ciphertext=0, rf_round=0, key_idx=0.
  - Reset overrides all other inputs. Reset mid-ROUND or in DONE discards the block; no partial result is ever flagged valid.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid=1 at an edge: state<=plaintext, rnd<=0, go to ROUND.
- ROUND:
  - rf_round=key_idx=rnd.
  - Each edge: state<=rf_out.
  - If rnd==NUM_ROUNDS-1: rnd<=NUM_ROUNDS and go to FINAL; else rnd<=rnd+1.
- FINAL:
  - key_idx=NUM_ROUNDS.
  - Edge: state<=state XOR rk_in, go to DONE.
- DONE:
  - out_valid=1, ciphertext=state.
  - If out_ready=1 at an edge: go to IDLE; out_valid drops the next cycle.
  - State holds until then, with no timeout.
- Latency and throughput:
  - Accept edge e0; round edges e1..eNUM_ROUNDS; final edge e(NUM_ROUNDS+1).
  - out_valid is first high the cycle after e(NUM_ROUNDS+1), i.e. 26 edges after accept at default.
  - Minimum spacing between accepted blocks is NUM_ROUNDS+3 cycles.
- Handshake rules:
  - in_ready=0 in ROUND, FINAL and DONE; in_valid and plaintext are ignored there.
  - Nothing is queued. A new block cannot be accepted on the same edge that DONE completes.
- Combinational outputs:
  - rf_in is driven by the state register in every state.
  - rf_round and key_idx are 0 in IDLE and DONE.
  - rf_out is used only in ROUND; rk_in is used only in FINAL.
- Counter rules:
  - rnd never exceeds NUM_ROUNDS.
  - Counter wrap is impossible by construction. Unsigned compare at CNT_W bits.

Test Plan:
1. Bench model rf_out=rf_in+1, rk_in=64'hA5A5_0000_0000_0000 | key_idx; plaintext=0, out_ready=1 -> out_valid rises 26 edges after accept; ciphertext=64'hA5A5_0000_0000_0000; rf_round sequence 0..24; key_idx=25 in FINAL.
2. Backpressure: same stimulus with out_ready=0 for 10 cycles after out_valid -> out_valid and ciphertext stay constant, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
3. in_valid=1 with plaintext=64'hFFFF held continuously -> exactly one block accepted per NUM_ROUNDS+3 cycles; blocks offered while busy are not captured.
4. Reset mid-operation: rst_n=0 for one edge while rnd=12 -> next cycle IDLE, state=0, busy=0, out_valid=0; a new block then completes normally with the result of scenario 1.
5. NUM_ROUNDS=1, plaintext=64'h10, same bench model -> one ROUND edge (state=0x11); FINAL with key_idx=1 gives ciphertext=64'hA5A5_0000_0000_0010; out_valid 2 edges after accept.

Source files
------------

// File: rtl/boron_round_ctrl.sv
// Iterative round sequencer for the BORON 64-bit block cipher: owns the cipher
// state and round counter, steps the external round function, then whitens.
module boron_round_ctrl #(
  parameter int NUM_ROUNDS = 25,
  parameter int BLOCK_W    = 64,
  parameter int CNT_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
  output logic [BLOCK_W-1:0] rf_in,
  output logic [CNT_W-1:0]   rf_round,
  input  logic [BLOCK_W-1:0] rf_out,
  output logic [CNT_W-1:0]   key_idx,
  input  logic [BLOCK_W-1:0] rk_in,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext
);

  localparam logic [CNT_W-1:0] LAST_RND  = CNT_W'(NUM_ROUNDS - 1);
  localparam logic [CNT_W-1:0] FINAL_IDX = CNT_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } fsm_t;

  fsm_t               fsm_reg, fsm_next;
  logic [BLOCK_W-1:0] state_reg, state_next;
  logic [CNT_W-1:0]   rnd_reg, rnd_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg   <= S_IDLE;
      state_reg <= '0;
      rnd_reg   <= '0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
    end
  end

  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    rnd_next   = rnd_reg;
    case (fsm_reg)
      S_IDLE: begin
        if (in_valid) begin
          state_next = plaintext;
          rnd_next   = '0;
          fsm_next   = S_ROUND;
        end
      end
      S_ROUND: begin
        state_next = rf_out;
        if (rnd_reg == LAST_RND) begin
          rnd_next = FINAL_IDX;
          fsm_next = S_FINAL;
        end else begin
          rnd_next = rnd_reg + 1'b1;
        end
      end
      S_FINAL: begin
        // Final key whitening with the round key at index NUM_ROUNDS.
        state_next = state_reg ^ rk_in;
        fsm_next   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) fsm_next = S_IDLE;
      end
      default: fsm_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    rf_round   = '0;
    key_idx    = '0;
    rf_in      = state_reg;
    ciphertext = state_reg;
    case (fsm_reg)
      S_IDLE:  in_ready = 1'b1;
      S_ROUND: begin
        busy     = 1'b1;
        rf_round = rnd_reg;
        key_idx  = rnd_reg;
      end
      S_FINAL: begin
        busy    = 1'b1;
        key_idx = FINAL_IDX;
      end
      S_DONE:  out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

endmodule
